// File: rtl/fragment_writer.sv
// Fragment sink: depth test via read/compare/write on depth memory, RGB565 packing, framebuffer write.
// Optional build macro FRAG_WRITER_DITHER_EN enables a 4x4 ordered dither ahead of channel truncation.
module fragment_writer #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int ADDR_W       = 19,
  parameter int DEPTH_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frag_valid,
  output logic              frag_ready,
  input  logic [11:0]       frag_x,
  input  logic [11:0]       frag_y,
  input  logic [31:0]       frag_z,
  input  logic [31:0]       frag_r,
  input  logic [31:0]       frag_g,
  input  logic [31:0]       frag_b,
  input  logic              z_test_en,
  output logic              z_rd_en,
  output logic [ADDR_W-1:0] z_rd_addr,
  input  logic [15:0]       z_rd_data,
  output logic              z_wr_en,
  output logic [ADDR_W-1:0] z_wr_addr,
  output logic [15:0]       z_wr_data,
  output logic              fb_wr_en,
  input  logic              fb_wr_ready,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [15:0]       fb_wr_data,
  input  logic              stats_clr,
  output logic [31:0]       cnt_written,
  output logic [31:0]       cnt_zfail,
  output logic [31:0]       cnt_clip
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  localparam int CNT_W = (DEPTH_RD_LAT > 1) ? $clog2(DEPTH_RD_LAT) : 1;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       znew_reg;
  logic [15:0]       color_reg;
  logic              zen_reg;
  logic [31:0]       written_reg, zfail_reg, clip_reg;

  logic              load, inc_written, inc_zfail, inc_clip;
  logic              clip;
  logic [ADDR_W-1:0] frag_addr;
  logic [15:0]       znew, r_frac, g_frac, b_frac, pack_color;
  logic              unused_frac;

  // S15.16 -> 16-bit fraction: negatives clamp to 0, 1.0 and above clamp to full scale
  function automatic logic [15:0] sat16(input logic [31:0] v);
    if (v[31])
      return 16'h0000;
    else if (v[30:16] != 15'd0)
      return 16'hFFFF;
    else
      return v[15:0];
  endfunction

`ifdef FRAG_WRITER_DITHER_EN
  function automatic logic [3:0] dither_m(input logic [1:0] yy, input logic [1:0] xx);
    case ({yy, xx})
      4'h0: return 4'd0;   4'h1: return 4'd8;   4'h2: return 4'd2;   4'h3: return 4'd10;
      4'h4: return 4'd12;  4'h5: return 4'd4;   4'h6: return 4'd14;  4'h7: return 4'd6;
      4'h8: return 4'd3;   4'h9: return 4'd11;  4'hA: return 4'd1;   4'hB: return 4'd9;
      4'hC: return 4'd15;  4'hD: return 4'd7;   4'hE: return 4'd13;  default: return 4'd5;
    endcase
  endfunction

  function automatic logic [15:0] add_sat(input logic [15:0] f, input logic [10:0] d);
    logic [16:0] s;
    s = {1'b0, f} + {6'd0, d};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [3:0] dm;
  always_comb begin
    dm     = dither_m(frag_y[1:0], frag_x[1:0]);
    r_frac = add_sat(sat16(frag_r), {dm, 7'd0});
    g_frac = add_sat(sat16(frag_g), {1'b0, dm, 6'd0});
    b_frac = add_sat(sat16(frag_b), {dm, 7'd0});
  end
`else
  always_comb begin
    r_frac = sat16(frag_r);
    g_frac = sat16(frag_g);
    b_frac = sat16(frag_b);
  end
`endif

  assign pack_color  = {r_frac[15:11], g_frac[15:10], b_frac[15:11]};
  assign unused_frac = ^{r_frac[10:0], g_frac[9:0], b_frac[10:0]};
  assign znew        = sat16(frag_z);
  assign frag_addr   = ADDR_W'(32'(frag_y) * 32'(SCREEN_W) + 32'(frag_x));
  assign clip        = (32'(frag_x) >= 32'(SCREEN_W)) || (32'(frag_y) >= 32'(SCREEN_H));

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    load         = 1'b0;
    inc_written  = 1'b0;
    inc_zfail    = 1'b0;
    inc_clip     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frag_valid) begin
          if (clip) begin
            inc_clip = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = z_test_en ? RD : WR;
          end
        end
      end
      RD: begin
        lat_cnt_next = '0;
        state_next   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_reg == CNT_W'(DEPTH_RD_LAT - 1)) begin
          // Strictly nearer wins; equal depth is rejected
          if (znew_reg < z_rd_data) begin
            state_next = WR;
          end else begin
            inc_zfail  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          lat_cnt_next = lat_cnt_reg + CNT_W'(1);
        end
      end
      WR: begin
        if (fb_wr_ready) begin
          inc_written = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      addr_reg    <= '0;
      znew_reg    <= '0;
      color_reg   <= '0;
      zen_reg     <= 1'b0;
      written_reg <= '0;
      zfail_reg   <= '0;
      clip_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      if (load) begin
        addr_reg  <= frag_addr;
        znew_reg  <= znew;
        color_reg <= pack_color;
        zen_reg   <= z_test_en;
      end
      if (stats_clr) begin
        written_reg <= '0;
        zfail_reg   <= '0;
        clip_reg    <= '0;
      end else begin
        if (inc_written) written_reg <= written_reg + 32'd1;
        if (inc_zfail)   zfail_reg   <= zfail_reg + 32'd1;
        if (inc_clip)    clip_reg    <= clip_reg + 32'd1;
      end
    end
  end

  assign frag_ready  = (state_reg == IDLE);
  assign z_rd_en     = (state_reg == RD);
  assign z_rd_addr   = addr_reg;
  assign fb_wr_en    = (state_reg == WR);
  assign fb_wr_addr  = addr_reg;
  assign fb_wr_data  = color_reg;
  assign z_wr_en     = (state_reg == WR) && fb_wr_ready && zen_reg;
  assign z_wr_addr   = addr_reg;
  assign z_wr_data   = znew_reg;
  assign cnt_written = written_reg;
  assign cnt_zfail   = zfail_reg;
  assign cnt_clip    = clip_reg;

endmodule

// File: tb/tb_fragment_writer.sv
// Scoreboarded bench for fragment_writer: expected framebuffer/depth writes are queued at send time
// and popped by a monitor on each framebuffer handshake; a behavioural depth memory answers reads.
module tb_fragment_writer;
  localparam int LAT = 1;
  localparam int AW  = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0, frag_valid = 1'b0, frag_ready, z_test_en = 1'b0;
  logic [11:0]   frag_x = '0, frag_y = '0;
  logic [31:0]   frag_z = '0, frag_r = '0, frag_g = '0, frag_b = '0;
  logic          z_rd_en, z_wr_en, fb_wr_en, fb_wr_ready = 1'b1, stats_clr = 1'b0;
  logic [AW-1:0] z_rd_addr, z_wr_addr, fb_wr_addr;
  logic [15:0]   z_rd_data = '0, z_wr_data, fb_wr_data;
  logic [31:0]   cnt_written, cnt_zfail, cnt_clip;

  fragment_writer #(.SCREEN_W(640), .SCREEN_H(480), .ADDR_W(AW), .DEPTH_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z), .frag_r(frag_r), .frag_g(frag_g),
    .frag_b(frag_b), .z_test_en(z_test_en), .z_rd_en(z_rd_en), .z_rd_addr(z_rd_addr),
    .z_rd_data(z_rd_data), .z_wr_en(z_wr_en), .z_wr_addr(z_wr_addr), .z_wr_data(z_wr_data),
    .fb_wr_en(fb_wr_en), .fb_wr_ready(fb_wr_ready), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .stats_clr(stats_clr), .cnt_written(cnt_written),
    .cnt_zfail(cnt_zfail), .cnt_clip(cnt_clip)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Depth memory with a one-cycle registered read
  logic [15:0] zmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (z_rd_en) z_rd_data <= zmem[z_rd_addr];
    if (z_wr_en) zmem[z_wr_addr] <= z_wr_data;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          zw;
    logic [15:0]   zd;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int errors = 0, checks = 0;
  int rd_count = 0, hs_count = 0, rd_cyc = -1, fb_rise_cyc = -1, hs_cyc = -1;
  logic fb_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (z_rd_en) begin rd_count++; rd_cyc = cyc; end
      if (fb_wr_en && !fb_prev) fb_rise_cyc = cyc;
      checks++;
      if (fb_wr_en && fb_wr_ready) begin
        hs_count++;
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%h zw=%b, required no write", fb_wr_addr, fb_wr_data, z_wr_en);
        end else begin
          e = exp_q.pop_front();
          if (fb_wr_addr !== e.addr || fb_wr_data !== e.data || z_wr_en !== e.zw ||
              (e.zw && z_wr_data !== e.zd)) begin
            errors++;
            $display("FAIL fb_write: addr=%0d data=%h zw=%b zd=%h, required addr=%0d data=%h zw=%b zd=%h",
                     fb_wr_addr, fb_wr_data, z_wr_en, z_wr_data, e.addr, e.data, e.zw, e.zd);
          end
          $display("write addr=%0d data=%h zw=%b zd=%h", fb_wr_addr, fb_wr_data, z_wr_en, z_wr_data);
        end
      end else if (z_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL z_wr_no_handshake: z_wr_en=%b, required 0", z_wr_en);
      end
      fb_prev = fb_wr_en;
    end else begin
      fb_prev = 1'b0;
    end
  end

  function automatic logic [15:0] sat16(input logic [31:0] v);
    if (v[31]) return 16'h0000;
    if (v >= 32'h10000) return 16'hFFFF;
    return v[15:0];
  endfunction

  function automatic int dmat(input int x, input int y);
    case ((y % 4) * 4 + (x % 4))
      0: return 0;   1: return 8;   2: return 2;   3: return 10;
      4: return 12;  5: return 4;   6: return 14;  7: return 6;
      8: return 3;   9: return 11;  10: return 1;  11: return 9;
      12: return 15; 13: return 7;  14: return 13; default: return 5;
    endcase
  endfunction

  function automatic logic [15:0] pack(input int x, input int y, input logic [31:0] r, g, b);
    int fr, fg, fb;
    logic [15:0] vr, vg, vb;
    fr = int'(sat16(r));
    fg = int'(sat16(g));
    fb = int'(sat16(b));
`ifdef FRAG_WRITER_DITHER_EN
    fr = fr + (dmat(x, y) << 7); if (fr > 65535) fr = 65535;
    fg = fg + (dmat(x, y) << 6); if (fg > 65535) fg = 65535;
    fb = fb + (dmat(x, y) << 7); if (fb > 65535) fb = 65535;
`else
    if (dmat(x, y) < 0) fr = 0;
`endif
    vr = 16'(fr); vg = 16'(fg); vb = 16'(fb);
    return {vr[15:11], vg[15:10], vb[15:11]};
  endfunction

  function automatic int addr_of(input int x, input int y);
    return y * 640 + x;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_wr(input int a, input logic [15:0] d, input logic zw, input logic [15:0] zd);
    exp_t n;
    n.addr = AW'(a); n.data = d; n.zw = zw; n.zd = zd;
    exp_q.push_back(n);
  endtask

  // Holds frag_valid until accepted; t is the cycle on whose closing edge the handshake happens
  task automatic send(input int x, input int y, input logic [31:0] z, r, g, b, input logic zen, output int t);
    int n;
    frag_x = 12'(x); frag_y = 12'(y); frag_z = z; frag_r = r; frag_g = g; frag_b = b;
    z_test_en = zen; frag_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!frag_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!frag_ready) begin
      errors++;
      $display("FAIL accept_timeout: frag_ready=%b after %0d cycles, required 1", frag_ready, n);
    end
    t = cyc;
    $display("send x=%0d y=%0d z=%h zen=%b cyc=%0d", x, y, z, zen, t);
    tick();
    frag_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !frag_ready) && n < 60) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0 || !frag_ready) begin
      errors++;
      $display("FAIL idle_timeout: pending=%0d frag_ready=%b, required 0 and 1", exp_q.size(), frag_ready);
    end
    tick();
  endtask

  task automatic wait_ready(output int rc);
    int n = 0;
    @(negedge clk);
    while (!frag_ready && n < 60) begin @(negedge clk); n++; end
    rc = cyc;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frag_valid = 1'b0; stats_clr = 1'b0; fb_wr_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (frag_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b, required 1", frag_ready); end
    checks++; if ({z_rd_en, z_wr_en, fb_wr_en} !== 3'b000) begin errors++; $display("FAIL reset_strobes: %b, required 000", {z_rd_en, z_wr_en, fb_wr_en}); end
    checks++; if ({z_rd_addr, z_wr_addr, fb_wr_addr, z_wr_data, fb_wr_data} !== '0) begin errors++; $display("FAIL reset_outputs: rd=%0d wr=%0d fb=%0d zd=%h fd=%h, required 0", z_rd_addr, z_wr_addr, fb_wr_addr, z_wr_data, fb_wr_data); end
    checks++; if ({cnt_written, cnt_zfail, cnt_clip} !== '0) begin errors++; $display("FAIL reset_counters: %0d %0d %0d, required 0 0 0", cnt_written, cnt_zfail, cnt_clip); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_depth();
    int t, rd0;
    rd0 = rd_count;
    expect_wr(1283, 16'hFC00, 1'b0, 16'h0);
    send(3, 2, 32'h0, 32'h10000, 32'h8000, 32'hFFFFFFFF, 1'b0, t);
    wait_idle();
    checks++; if (fb_rise_cyc !== t + 1) begin errors++; $display("FAIL nodepth_latency: fb_wr_en at %0d, required %0d", fb_rise_cyc, t + 1); end
    checks++; if (rd_count !== rd0) begin errors++; $display("FAIL nodepth_rd: reads=%0d, required %0d", rd_count, rd0); end
    checks++; if (cnt_written !== 32'd1) begin errors++; $display("FAIL nodepth_written: %0d, required 1", cnt_written); end
  endtask

  task automatic test_zpass();
    int t, rc, rd0, a;
    a = addr_of(10, 5); rd0 = rd_count;
    zmem[a] = 16'h8000;
    expect_wr(a, pack(10, 5, 32'h4000, 32'h2000, 32'hC000), 1'b1, 16'h4000);
    send(10, 5, 32'h4000, 32'h4000, 32'h2000, 32'hC000, 1'b1, t);
    wait_ready(rc);
    checks++; if (rd_count !== rd0 + 1 || rd_cyc !== t + 1) begin errors++; $display("FAIL zpass_rd: reads=%0d at %0d, required %0d at %0d", rd_count - rd0, rd_cyc, 1, t + 1); end
    checks++; if (fb_rise_cyc !== t + 2 + LAT) begin errors++; $display("FAIL zpass_fb_latency: %0d, required %0d", fb_rise_cyc, t + 2 + LAT); end
    checks++; if (rc !== t + 3 + LAT) begin errors++; $display("FAIL zpass_ready: %0d, required %0d", rc, t + 3 + LAT); end
    checks++; if (zmem[a] !== 16'h4000) begin errors++; $display("FAIL zpass_depth: %h, required 4000", zmem[a]); end
    checks++; if (cnt_written !== 32'd2) begin errors++; $display("FAIL zpass_written: %0d, required 2", cnt_written); end
  endtask

  task automatic test_zfail();
    int t, rc, hs0;
    logic [31:0] zv [2];
    zv[0] = 32'h9000; zv[1] = 32'h8000;
    hs0 = hs_count;
    zmem[addr_of(20, 7)] = 16'h8000;
    for (int i = 0; i < 2; i++) begin
      send(20, 7, zv[i], 32'h10000, 32'h10000, 32'h10000, 1'b1, t);
      wait_ready(rc);
      checks++; if (rc !== t + 2 + LAT) begin errors++; $display("FAIL zfail_ready_%0d: %0d, required %0d", i, rc, t + 2 + LAT); end
    end
    checks++; if (cnt_zfail !== 32'd2) begin errors++; $display("FAIL zfail_count: %0d, required 2", cnt_zfail); end
    checks++; if (hs_count !== hs0) begin errors++; $display("FAIL zfail_writes: %0d, required 0", hs_count - hs0); end
  endtask

  task automatic test_clip();
    int t, rd0, hs0;
    rd0 = rd_count; hs0 = hs_count;
    send(640, 0, 32'h0, 32'h10000, 32'h0, 32'h0, 1'b1, t);
    @(negedge clk);
    checks++; if (frag_ready !== 1'b1) begin errors++; $display("FAIL clip_ready_x: %b, required 1", frag_ready); end
    tick();
    send(0, 480, 32'h0, 32'h10000, 32'h0, 32'h0, 1'b0, t);
    @(negedge clk);
    checks++; if (frag_ready !== 1'b1) begin errors++; $display("FAIL clip_ready_y: %b, required 1", frag_ready); end
    tick();
    checks++; if (rd_count !== rd0 || hs_count !== hs0) begin errors++; $display("FAIL clip_access: reads=%0d writes=%0d, required 0 0", rd_count - rd0, hs_count - hs0); end
    checks++; if (cnt_clip !== 32'd2) begin errors++; $display("FAIL clip_count: %0d, required 2", cnt_clip); end
  endtask

  task automatic test_backpressure();
    int t, a;
    logic [15:0] d;
    a = addr_of(100, 50);
    d = pack(100, 50, 32'h1234, 32'h8765, 32'hFFFF);
    fb_wr_ready = 1'b0;
    expect_wr(a, d, 1'b0, 16'h0);
    send(100, 50, 32'h0, 32'h1234, 32'h8765, 32'hFFFF, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (fb_wr_en !== 1'b1 || fb_wr_addr !== AW'(a) || fb_wr_data !== d || frag_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: en=%b addr=%0d data=%h ready=%b, required 1 %0d %h 0", i, fb_wr_en, fb_wr_addr, fb_wr_data, frag_ready, a, d);
      end
      tick();
    end
    fb_wr_ready = 1'b1;
    wait_idle();
    checks++; if (hs_cyc !== t + 6) begin errors++; $display("FAIL stall_complete: %0d, required %0d", hs_cyc, t + 6); end
  endtask

  task automatic test_stats_clr();
    int t;
    fb_wr_ready = 1'b0;
    expect_wr(addr_of(7, 9), pack(7, 9, 32'h0, 32'h0, 32'h0), 1'b0, 16'h0);
    send(7, 9, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, t);
    stats_clr = 1'b1; fb_wr_ready = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    checks++; if ({cnt_written, cnt_zfail, cnt_clip} !== '0) begin errors++; $display("FAIL clr_priority: %0d %0d %0d, required 0 0 0", cnt_written, cnt_zfail, cnt_clip); end
    tick();
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int t, hs0;
    hs0 = hs_count;
    zmem[addr_of(30, 30)] = 16'h8000;
    send(30, 30, 32'h1000, 32'h10000, 32'h10000, 32'h10000, 1'b1, t);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (frag_ready !== 1'b1 || {z_rd_en, z_wr_en, fb_wr_en} !== 3'b000) begin errors++; $display("FAIL midreset_state: ready=%b strobes=%b, required 1 000", frag_ready, {z_rd_en, z_wr_en, fb_wr_en}); end
    checks++; if ({z_rd_addr, fb_wr_addr, z_wr_data, fb_wr_data} !== '0) begin errors++; $display("FAIL midreset_outputs: %0d %0d %h %h, required 0", z_rd_addr, fb_wr_addr, z_wr_data, fb_wr_data); end
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    checks++; if (hs_count !== hs0 || cnt_written !== 32'd0) begin errors++; $display("FAIL midreset_stale: writes=%0d cnt=%0d, required 0 0", hs_count - hs0, cnt_written); end
  endtask

  task automatic test_back_to_back();
    int t, tp;
    logic [31:0] r;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      r = 32'($urandom_range(0, 32'h10000));
      expect_wr(addr_of(i, 100), pack(i, 100, r, ~r, 32'h8000), 1'b0, 16'h0);
      send(i, 100, 32'h0, r, ~r, 32'h8000, 1'b0, t);
      if (i > 0) begin
        checks++; if (t - tp !== 2) begin errors++; $display("FAIL b2b_spacing_%0d: %0d, required 2", i, t - tp); end
      end
      tp = t;
    end
    wait_idle();
  endtask

  task automatic test_dither_corners();
    int t;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        expect_wr(addr_of(x + 200, y + 200), 16'hFFFF, 1'b0, 16'h0);
        send(x + 200, y + 200, 32'h0, 32'h10000, 32'h10000, 32'h10000, 1'b0, t);
        expect_wr(addr_of(x + 200, y + 200), 16'h0000, 1'b0, 16'h0);
        send(x + 200, y + 200, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, t);
      end
    wait_idle();
  endtask

  task automatic test_random();
    int t, x, y, a, ew, ez, ec;
    logic [31:0] z, r, g, b;
    logic zen;
    logic [15:0] zn;
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    ew = 0; ez = 0; ec = 0;
    for (int i = 0; i < 30; i++) begin
      x = $urandom_range(0, 660); y = $urandom_range(0, 495);
      z = 32'($urandom_range(0, 32'h14000)) - 32'h2000;
      r = 32'($urandom_range(0, 32'h14000)) - 32'h2000;
      g = 32'($urandom_range(0, 32'h12000)) - 32'h1000;
      b = 32'($urandom_range(0, 32'h11000)) - 32'h800;
      zen = 1'($urandom_range(0, 1));
      if (x >= 640 || y >= 480) begin
        ec++;
      end else begin
        a = addr_of(x, y);
        zmem[a] = 16'($urandom_range(0, 16'hFFFF));
        zn = sat16(z);
        if (!zen) begin ew++; expect_wr(a, pack(x, y, r, g, b), 1'b0, 16'h0); end
        else if (zn < zmem[a]) begin ew++; expect_wr(a, pack(x, y, r, g, b), 1'b1, zn); end
        else ez++;
      end
      send(x, y, z, r, g, b, zen, t);
      wait_idle();
    end
    checks++; if (cnt_written !== 32'(ew) || cnt_zfail !== 32'(ez) || cnt_clip !== 32'(ec)) begin errors++; $display("FAIL random_counters: %0d %0d %0d, required %0d %0d %0d", cnt_written, cnt_zfail, cnt_clip, ew, ez, ec); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) zmem[i] = 16'hFFFF;
    test_reset();
    test_no_depth();
    test_zpass();
    test_zfail();
    test_clip();
    test_backpressure();
    test_stats_clr();
    test_reset_mid();
    test_back_to_back();
    test_dither_corners();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
